// File: rtl/ncpu32k_ibus_sram_resp.sv
// ncpu32k_ibus_sram_resp
// ----------------------------------------------------------------------------
// Instruction-side frontbus responder. Accepts fetch requests on the A
// channel, reads one word from an external synchronous SRAM and returns the
// word plus an exception code on the B channel through a small response FIFO.
// Requests that carry an upstream exception, are misaligned or fall outside
// the attached SRAM are answered directly without an SRAM access.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ibus_AREADY     responder can accept a request
//   ibus_AVALID     request valid
//   ibus_AADDR      byte address of the instruction
//   ibus_AEXC       upstream exception code attached to the request
//   ibus_BVALID     response valid
//   ibus_BREADY     requester accepts the response
//   ibus_BDATA      instruction word
//   ibus_BEXC       response exception code
//   mem_en          SRAM read enable (one cycle per normal request)
//   mem_addr        SRAM word address (holds its value outside a read)
//   mem_dout        SRAM read data, valid the cycle after mem_en
//
// Optional feature macro: NCPU_IBUS_RESP_BYPASS_EN
//   When defined, the SRAM word is forwarded combinationally to the B channel
//   in the capture cycle if the response FIFO is empty, saving one cycle.
//   When undefined, every response is served from the FIFO registers.
// ----------------------------------------------------------------------------
`ifndef NCPU_AW
`define NCPU_AW 32
`endif
`ifndef NCPU_IW
`define NCPU_IW 32
`endif

module ncpu32k_ibus_sram_resp #(
  parameter int CONFIG_MEM_AW      = 12,
  parameter int CONFIG_WAIT_CYCLES = 0,
  parameter int CONFIG_RESP_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ibus_AREADY,
  input  logic                     ibus_AVALID,
  input  logic [`NCPU_AW-1:0]      ibus_AADDR,
  input  logic [1:0]               ibus_AEXC,
  output logic                     ibus_BVALID,
  input  logic                     ibus_BREADY,
  output logic [`NCPU_IW-1:0]      ibus_BDATA,
  output logic [1:0]               ibus_BEXC,
  output logic                     mem_en,
  output logic [CONFIG_MEM_AW-1:0] mem_addr,
  input  logic [`NCPU_IW-1:0]      mem_dout
);

  localparam int PTR_W = $clog2(CONFIG_RESP_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [3:0] WAIT_INIT =
    (CONFIG_WAIT_CYCLES > 0) ? 4'(CONFIG_WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_CAPT = 2'd3
  } state_t;

  // Priority: upstream exception, then misalignment, then out-of-range.
  function automatic logic [1:0] f_classify(input logic [`NCPU_AW-1:0] addr,
                                            input logic [1:0]          exc);
    if (exc != 2'b00)
      return exc;
    else if (addr[1:0] != 2'b00)
      return 2'b01;
    else if ((addr >> (CONFIG_MEM_AW + 2)) != '0)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [3:0]               r_wcnt;
  logic [CONFIG_MEM_AW-1:0] r_req_addr;
  logic [CONFIG_MEM_AW-1:0] r_mem_addr;

  logic [`NCPU_IW-1:0]      r_fifo_data [CONFIG_RESP_DEPTH];
  logic [1:0]               r_fifo_exc  [CONFIG_RESP_DEPTH];
  logic [PTR_W:0]           r_wptr;
  logic [PTR_W:0]           r_rptr;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_accept;
  logic [1:0]               w_req_exc;
  logic                     w_normal;
  logic                     w_exc_push;
  logic                     w_capt;
  logic                     w_byp;
  logic                     w_push;
  logic                     w_pop;
  logic [`NCPU_IW-1:0]      w_push_data;
  logic [1:0]               w_push_exc;
  logic [CONFIG_MEM_AW-1:0] w_acc_word;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  assign w_accept   = ibus_AVALID && ibus_AREADY;
  assign w_req_exc  = f_classify(ibus_AADDR, ibus_AEXC);
  assign w_normal   = w_accept && (w_req_exc == 2'b00);
  assign w_exc_push = w_accept && (w_req_exc != 2'b00);
  assign w_acc_word = ibus_AADDR[CONFIG_MEM_AW+1:2];
  assign w_capt     = (r_state == S_CAPT);

`ifdef NCPU_IBUS_RESP_BYPASS_EN
  assign w_byp = w_capt && w_empty;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed word taken by the requester in the capture cycle is never
  // stored. Accepts happen only in IDLE, so the two push sources never
  // collide.
  assign w_push      = w_exc_push || (w_capt && !(w_byp && ibus_BREADY));
  assign w_push_data = w_capt ? mem_dout : '0;
  assign w_push_exc  = w_capt ? 2'b00 : w_req_exc;
  assign w_pop       = !w_empty && ibus_BREADY;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_normal)
                w_state_nxt = (CONFIG_WAIT_CYCLES > 0) ? S_WAIT : S_READ;
      S_WAIT: if (r_wcnt == 4'd0) w_state_nxt = S_READ;
      S_READ: w_state_nxt = S_CAPT;
      S_CAPT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: ready only when idle and a response slot is guaranteed
  always_comb begin
    mem_en      = (r_state == S_READ);
    ibus_AREADY = (r_state == S_IDLE) && !w_full;
  end

  // Wait-state counter and address latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt     <= 4'd0;
      r_req_addr <= '0;
      r_mem_addr <= '0;
    end else begin
      if (w_normal) begin
        r_wcnt     <= WAIT_INIT;
        r_req_addr <= w_acc_word;
      end else if ((r_state == S_WAIT) && (r_wcnt != 4'd0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      // mem_addr only moves when a read is about to be issued.
      if ((w_state_nxt == S_READ) && (r_state != S_READ))
        r_mem_addr <= (r_state == S_IDLE) ? w_acc_word : r_req_addr;
    end
  end

  assign mem_addr = r_mem_addr;

  // Response FIFO. Storage is cleared on reset so BDATA/BEXC read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < CONFIG_RESP_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_exc[i]  <= 2'b00;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr[PTR_W-1:0]] <= w_push_data;
        r_fifo_exc[r_wptr[PTR_W-1:0]]  <= w_push_exc;
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
    end
  end

`ifdef NCPU_IBUS_RESP_BYPASS_EN
  always_comb begin
    ibus_BVALID = !w_empty;
    ibus_BDATA  = r_fifo_data[r_rptr[PTR_W-1:0]];
    ibus_BEXC   = r_fifo_exc[r_rptr[PTR_W-1:0]];
    if (w_byp) begin
      ibus_BVALID = 1'b1;
      ibus_BDATA  = mem_dout;
      ibus_BEXC   = 2'b00;
    end
  end
`else
  assign ibus_BVALID = !w_empty;
  assign ibus_BDATA  = r_fifo_data[r_rptr[PTR_W-1:0]];
  assign ibus_BEXC   = r_fifo_exc[r_rptr[PTR_W-1:0]];
`endif

endmodule

// File: tb/tb_ncpu32k_ibus_sram_resp.sv
module tb_ncpu32k_ibus_sram_resp;

  localparam int MEM_AW = 12;
  localparam int DEPTH  = 2;
`ifdef NCPU_IBUS_RESP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          vis;     // first cycle the response may be seen
    int          rd;      // cycle of the SRAM read, -1 for none
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  exc;
    bit          normal;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tcyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        aready [2];
  logic        avalid [2];
  logic [31:0] aaddr  [2];
  logic [1:0]  aexc   [2];
  logic        bvalid [2];
  logic        bready [2];
  logic [31:0] bdata  [2];
  logic [1:0]  bexc   [2];
  logic        men    [2];
  logic [11:0] maddr  [2];
  logic [31:0] mdout  [2];

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  function automatic logic [31:0] sram_val(input logic [11:0] a);
    return (a == 12'd5) ? 32'h12345678 : {20'hC0DE0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : 3;

    ncpu32k_ibus_sram_resp #(
      .CONFIG_MEM_AW(MEM_AW), .CONFIG_WAIT_CYCLES(W), .CONFIG_RESP_DEPTH(DEPTH)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ibus_AREADY(aready[g]), .ibus_AVALID(avalid[g]),
      .ibus_AADDR(aaddr[g]), .ibus_AEXC(aexc[g]),
      .ibus_BVALID(bvalid[g]), .ibus_BREADY(bready[g]),
      .ibus_BDATA(bdata[g]), .ibus_BEXC(bexc[g]),
      .mem_en(men[g]), .mem_addr(maddr[g]), .mem_dout(mdout[g])
    );

    // Synchronous SRAM: data appears the cycle after the enable.
    always @(posedge clk) if (men[g]) mdout[g] <= sram_val(maddr[g]);

    ent_t        q[$];
    int          busy_until = -1;
    logic [11:0] last_addr = '0;

    always @(negedge clk) begin
      int   vcnt;
      bit   e_ar, e_bv, e_en;
      ent_t ne;
      logic [1:0] cls;
      if (!rst_n) begin
        q.delete();
        busy_until = -1;
        last_addr  = '0;
        chk($sformatf("rst_aready%0d", g), 32'(aready[g]), 32'd1);
        chk($sformatf("rst_bvalid%0d", g), 32'(bvalid[g]), 32'd0);
        chk($sformatf("rst_mem_en%0d", g), 32'(men[g]), 32'd0);
        chk($sformatf("rst_mem_addr%0d", g), 32'(maddr[g]), 32'd0);
      end else begin
        vcnt = 0;
        foreach (q[i]) if (q[i].vis <= tcyc) vcnt++;
        e_ar = (tcyc > busy_until) && (vcnt < DEPTH);
        e_bv = (q.size() > 0) &&
               ((q[0].vis <= tcyc) || (BYP && q[0].normal && q[0].vis == tcyc + 1));
        e_en = 1'b0;
        foreach (q[i]) if (q[i].rd == tcyc) begin e_en = 1'b1; last_addr = q[i].addr; end
        chk($sformatf("aready%0d", g), 32'(aready[g]), 32'(e_ar));
        chk($sformatf("bvalid%0d", g), 32'(bvalid[g]), 32'(e_bv));
        chk($sformatf("mem_en%0d", g), 32'(men[g]), 32'(e_en));
        chk($sformatf("mem_addr%0d", g), 32'(maddr[g]), 32'(last_addr));
        if (e_bv) begin
          chk($sformatf("bdata%0d", g), bdata[g], q[0].data);
          chk($sformatf("bexc%0d", g), 32'(bexc[g]), 32'(q[0].exc));
        end
        if (e_bv && bready[g]) void'(q.pop_front());
        if (e_ar && avalid[g]) begin
          if (aexc[g] != 2'b00) cls = aexc[g];
          else if (aaddr[g][1:0] != 2'b00) cls = 2'b01;
          else if ((aaddr[g] >> (MEM_AW + 2)) != 32'd0) cls = 2'b10;
          else cls = 2'b00;
          ne.addr   = aaddr[g][13:2];
          ne.exc    = cls;
          ne.normal = (cls == 2'b00);
          if (ne.normal) begin
            ne.rd      = tcyc + 1 + W;
            ne.vis     = tcyc + 3 + W;
            ne.data    = sram_val(ne.addr);
            busy_until = tcyc + 2 + W;
          end else begin
            ne.rd   = -1;
            ne.vis  = tcyc + 1;
            ne.data = 32'd0;
          end
          q.push_back(ne);
        end
      end
    end
  end

  task automatic send(input int k, input logic [31:0] a, input logic [1:0] e, output int acc);
    acc = -1;
    avalid[k] = 1'b1;
    aaddr[k]  = a;
    aexc[k]   = e;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (aready[k]) begin acc = tcyc; break; end
    end
    if (acc < 0) chk($sformatf("accept_timeout%0d", k), 32'd0, 32'd1);
    @(posedge clk); #1;
    avalid[k] = 1'b0;
  endtask

  // Issue one request with BREADY high and check offsets (relative to the
  // accept cycle) of the SRAM read and of the response.
  task automatic run_req(input string nm, input int k, input logic [31:0] a,
                         input logic [1:0] e, input int exp_en, input int exp_bv,
                         input logic [31:0] exp_d, input logic [1:0] exp_e);
    int acc, en_off, bv_off, ar1;
    logic [31:0] d;
    logic [1:0]  ex;
    logic [11:0] ma;
    send(k, a, e, acc);
    en_off = -1; bv_off = -1; ar1 = -1; d = '0; ex = '0; ma = '0;
    for (int n = 0; n < 40 && bv_off < 0; n++) begin
      @(negedge clk);
      if (tcyc == acc + 1) ar1 = 32'(aready[k]);
      if (men[k] && en_off < 0) begin en_off = tcyc - acc; ma = maddr[k]; end
      if (bvalid[k]) begin bv_off = tcyc - acc; d = bdata[k]; ex = bexc[k]; end
    end
    chk({nm, "_en_off"}, en_off, exp_en);
    chk({nm, "_bv_off"}, bv_off, exp_bv);
    chk({nm, "_bdata"}, d, exp_d);
    chk({nm, "_bexc"}, 32'(ex), 32'(exp_e));
    if (exp_en >= 0) begin
      chk({nm, "_mem_addr"}, 32'(ma), 32'(a[13:2]));
      chk({nm, "_busy_aready"}, ar1, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int got;
    logic [31:0] rd [2];
    logic [1:0]  re [2];
    bit seen;
    for (int k = 0; k < 2; k++) begin
      avalid[k] = 1'b0; aaddr[k] = '0; aexc[k] = 2'b00; bready[k] = 1'b1;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_aready", 32'(aready[k]), 32'd1);
      chk("reset_bvalid", 32'(bvalid[k]), 32'd0);
      chk("reset_bdata", bdata[k], 32'd0);
      chk("reset_bexc", 32'(bexc[k]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_req("w0_read", 0, 32'h14, 2'b00, 1, BYP ? 2 : 3, 32'h12345678, 2'b00);
    run_req("w3_read", 1, 32'h14, 2'b00, 4, BYP ? 5 : 6, 32'h12345678, 2'b00);
    run_req("w0_read2", 0, 32'h3FFC, 2'b00, 1, BYP ? 2 : 3, 32'hC0DE0FFF, 2'b00);
    run_req("misalign", 0, 32'h16, 2'b00, -1, 1, 32'd0, 2'b01);
    run_req("bus_err", 0, 32'h4000, 2'b00, -1, 1, 32'd0, 2'b10);
    run_req("aexc", 0, 32'h14, 2'b11, -1, 1, 32'd0, 2'b11);
    run_req("aexc_prio", 0, 32'h16, 2'b10, -1, 1, 32'd0, 2'b10);
    run_req("mis_prio", 0, 32'h4002, 2'b00, -1, 1, 32'd0, 2'b01);
    run_req("w3_exc", 1, 32'h4000, 2'b00, -1, 1, 32'd0, 2'b10);

    // Back-to-back exception accepts
    send(0, 32'h1, 2'b00, acc);
    send(0, 32'h4004, 2'b00, acc);
    send(0, 32'h8, 2'b01, acc);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: fill the FIFO, then drain in order
    bready[0] = 1'b0;
    send(0, 32'h20, 2'b00, acc);
    send(0, 32'h16, 2'b00, acc);
    @(negedge clk);
    chk("full_aready", 32'(aready[0]), 32'd0);
    chk("full_bvalid", 32'(bvalid[0]), 32'd1);
    @(posedge clk); #1;
    bready[0] = 1'b1;
    got = 0;
    for (int n = 0; n < 10 && got < 2; n++) begin
      @(negedge clk);
      if (bvalid[0]) begin rd[got] = bdata[0]; re[got] = bexc[0]; got++; end
    end
    chk("drain_count", got, 2);
    chk("drain0_data", rd[0], 32'hC0DE0008);
    chk("drain0_exc", 32'(re[0]), 32'd0);
    chk("drain1_data", rd[1], 32'd0);
    chk("drain1_exc", 32'(re[1]), 32'd1);
    @(negedge clk);
    chk("drain_aready", 32'(aready[0]), 32'd1);
    @(posedge clk); #1;

    // Response held while BREADY is low
    bready[0] = 1'b0;
    send(0, 32'h14, 2'b00, acc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_bvalid", 32'(bvalid[0]), 32'd1);
    chk("hold_bdata", bdata[0], 32'h12345678);
    @(posedge clk); #1;
    bready[0] = 1'b1;
    @(negedge clk);
    chk("release_bvalid", 32'(bvalid[0]), 32'd1);
    chk("release_bdata", bdata[0], 32'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    chk("released_bvalid", 32'(bvalid[0]), 32'd0);
    @(posedge clk); #1;

    // Reset during WAIT of an in-flight read
    send(1, 32'h14, 2'b00, acc);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bvalid", 32'(bvalid[1]), 32'd0);
    chk("midrst_aready", 32'(aready[1]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bvalid[1] || men[1]) seen = 1'b1;
    end
    chk("stale_resp", 32'(seen), 32'd0);
    @(posedge clk); #1;
    run_req("post_rst", 1, 32'h18, 2'b00, 4, BYP ? 5 : 6, 32'hC0DE0006, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
